// File: rtl/axi_ram_pkg.sv
// Shared types and helpers for the AXI4 burst RAM.
//   burst_t    : AXI burst encodings (2'b11 is handled as INCR by f_next_addr)
//   resp_t     : AXI response encodings used by this slave
//   wr_state_t : write channel FSM states
//   rd_state_t : read channel FSM states
//   f_wrap_len_ok : true for the only WRAP lengths AXI allows (2/4/8/16 beats)
//   f_next_addr   : address of the following beat of a burst
package axi_ram_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        SLVERR = 2'd2
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } rd_state_t;

    function automatic logic f_wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Addresses are carried at 64 bits here; callers zero-extend and truncate.
    // An illegal WRAP length falls through to INCR stepping.
    function automatic logic [63:0] f_next_addr(input logic [63:0] addr,
                                                input logic [2:0]  size,
                                                input logic [7:0]  len,
                                                input logic [1:0]  burst);
        logic [63:0] step;
        logic [63:0] mask;
        logic [63:0] nxt;
        step = 64'd1 << size;
        mask = (({56'd0, len} + 64'd1) * step) - 64'd1;
        if (burst == FIXED) begin
            nxt = addr;
        end else if ((burst == WRAP) && f_wrap_len_ok(len)) begin
            // Keep the aligned window base, step only inside the window.
            nxt = (addr & ~mask) | ((addr + step) & mask);
        end else begin
            nxt = addr + step;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/axi_ram_addr_gen.sv
// Burst address generator: latches the burst descriptor on load_i and steps
// the beat address on every adv_i.
//   clk, rst  : clock, synchronous active-high reset
//   load_i    : capture addr_i/len_i/size_i/burst_i, beat counter to 0
//   adv_i     : current beat consumed, move to the next address
//   addr_o    : byte address of the current beat
//   last_o    : current beat is the final one (beat index == len)
module axi_ram_addr_gen
    import axi_ram_pkg::*;
#(
    parameter int G_ADDRWIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   adv_i,
    input  logic [G_ADDRWIDTH-1:0] addr_i,
    input  logic [7:0]             len_i,
    input  logic [2:0]             size_i,
    input  logic [1:0]             burst_i,
    output logic [G_ADDRWIDTH-1:0] addr_o,
    output logic                   last_o
);

    logic [G_ADDRWIDTH-1:0] addr_q, addr_d;
    logic [7:0]             len_q, len_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [2:0]             size_q, size_d;
    logic [1:0]             burst_q, burst_d;
    logic [63:0]            next_addr;

    always_comb begin
        next_addr = f_next_addr(64'(addr_q), size_q, len_q, burst_q);
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        if (load_i) begin
            addr_d  = addr_i;
            len_d   = len_i;
            size_d  = size_i;
            burst_d = burst_i;
            cnt_d   = 8'd0;
        end else if (adv_i) begin
            addr_d = G_ADDRWIDTH'(next_addr);
            cnt_d  = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        len_q   <= len_d;
        size_q  <= size_d;
        burst_q <= burst_d;
    end

    assign addr_o = addr_q;
    assign last_o = (cnt_q == len_q);

endmodule

// File: rtl/axi_ram_burst.sv
// AXI4 slave RAM with INCR/WRAP/FIXED bursts, byte strobes and narrow
// transfers. One write burst and one read burst may be in flight at once.
// Ports:
//   s_aclk, s_areset     : clock, synchronous active-high reset
//   s_axi_aw* / s_axi_w* : write address / write data (wlast not used to end bursts)
//   s_axi_b*             : write response
//   s_axi_ar* / s_axi_r* : read address / read data
// Optional feature macro: AXI_RAM_RANGE_CHECK_EN -- bursts starting beyond the
// array or using an illegal WRAP length answer SLVERR, write nothing and read
// zeros. Without it addresses wrap modulo G_MEMDEPTH and responses are OKAY.
module axi_ram_burst
    import axi_ram_pkg::*;
#(
    parameter int    G_DATAWIDTH = 32,
    parameter int    G_MEMDEPTH  = 1024,
    parameter int    G_ID_WIDTH  = 4,
    parameter int    G_ADDRWIDTH = 32,
    parameter string G_INIT_FILE = ""
) (
    input  logic                     s_aclk,
    input  logic                     s_areset,
    input  logic [G_ID_WIDTH-1:0]    s_axi_awid,
    input  logic [G_ADDRWIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]               s_axi_awlen,
    input  logic [2:0]               s_axi_awsize,
    input  logic [1:0]               s_axi_awburst,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [G_DATAWIDTH-1:0]   s_axi_wdata,
    input  logic [G_DATAWIDTH/8-1:0] s_axi_wstrb,
    input  logic                     s_axi_wlast,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [G_ID_WIDTH-1:0]    s_axi_bid,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [G_ID_WIDTH-1:0]    s_axi_arid,
    input  logic [G_ADDRWIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]               s_axi_arlen,
    input  logic [2:0]               s_axi_arsize,
    input  logic [1:0]               s_axi_arburst,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [G_ID_WIDTH-1:0]    s_axi_rid,
    output logic [G_DATAWIDTH-1:0]   s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rlast,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready
);

    localparam int NBYTES = G_DATAWIDTH / 8;
    localparam int OFF    = $clog2(NBYTES);
    localparam int IDXW   = $clog2(G_MEMDEPTH);

    logic [G_DATAWIDTH-1:0] mem [G_MEMDEPTH];

    // ---------------------------------------------------------------- write
    wr_state_t              wr_state_q, wr_state_d;
    logic [G_ID_WIDTH-1:0]  bid_q, bid_d;
    logic                   wr_err_q, wr_err_d;
    logic                   aw_hs, w_hs, aw_err, wr_last, mem_we;
    logic [G_ADDRWIDTH-1:0] wr_addr;
    logic [IDXW-1:0]        wr_idx;

    assign s_axi_awready = (wr_state_q == W_IDLE);
    assign s_axi_wready  = (wr_state_q == W_DATA);
    assign s_axi_bvalid  = (wr_state_q == W_RESP);
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = wr_err_q ? SLVERR : OKAY;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign wr_idx = wr_addr[OFF+IDXW-1:OFF];

`ifdef AXI_RAM_RANGE_CHECK_EN
    assign aw_err = ((s_axi_awaddr >> OFF) >= G_ADDRWIDTH'(G_MEMDEPTH)) ||
                    ((s_axi_awburst == WRAP) && !f_wrap_len_ok(s_axi_awlen));
`else
    assign aw_err = 1'b0;
`endif

    axi_ram_addr_gen #(.G_ADDRWIDTH(G_ADDRWIDTH)) u_aw_gen (
        .clk     (s_aclk),
        .rst     (s_areset),
        .load_i  (aw_hs),
        .adv_i   (w_hs),
        .addr_i  (s_axi_awaddr),
        .len_i   (s_axi_awlen),
        .size_i  (s_axi_awsize),
        .burst_i (s_axi_awburst),
        .addr_o  (wr_addr),
        .last_o  (wr_last)
    );

    always_comb begin
        wr_state_d = wr_state_q;
        bid_d      = bid_q;
        wr_err_d   = wr_err_q;
        case (wr_state_q)
            W_IDLE: if (s_axi_awvalid) begin
                wr_state_d = W_DATA;
                bid_d      = s_axi_awid;
                wr_err_d   = aw_err;
            end
            // The beat counter alone ends the burst.
            W_DATA: if (s_axi_wvalid && wr_last) wr_state_d = W_RESP;
            W_RESP: if (s_axi_bready) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            wr_state_q <= W_IDLE;
            bid_q      <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            bid_q      <= bid_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // A beat coinciding with reset belongs to a dropped burst.
    assign mem_we = w_hs && !wr_err_q && !s_areset;

    always_ff @(posedge s_aclk) begin
        if (mem_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (s_axi_wstrb[b]) mem[wr_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // ----------------------------------------------------------------- read
    rd_state_t              rd_state_q, rd_state_d;
    logic [G_ID_WIDTH-1:0]  rid_q, rid_d;
    logic                   rd_err_q, rd_err_d;
    logic                   rd_done_q, rd_done_d;
    logic                   ar_hs, ar_err, rd_last, rd_issue, pop;
    logic [G_ADDRWIDTH-1:0] rd_addr;
    logic [IDXW-1:0]        rd_idx;
    logic [2:0]             committed;

    // Array output stage (one cycle behind issue)
    logic [G_DATAWIDTH-1:0] arr_data_q;
    logic                   arr_vld_q, arr_last_q;

    // Two-entry output buffer: head drives the R channel, skid catches the
    // beat already in the array stage when rready drops.
    logic [1:0]             occ_q, occ_d, after_pop;
    logic [G_DATAWIDTH-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d, push_data;
    logic                   head_last_q, head_last_d, skid_last_q, skid_last_d;

    assign s_axi_arready = (rd_state_q == R_IDLE);
    assign s_axi_rvalid  = (occ_q != 2'd0);
    assign s_axi_rdata   = head_data_q;
    assign s_axi_rlast   = s_axi_rvalid && head_last_q;
    assign s_axi_rresp   = rd_err_q ? SLVERR : OKAY;
    assign s_axi_rid     = rid_q;

    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign pop    = s_axi_rvalid && s_axi_rready;
    assign rd_idx = rd_addr[OFF+IDXW-1:OFF];

`ifdef AXI_RAM_RANGE_CHECK_EN
    assign ar_err = ((s_axi_araddr >> OFF) >= G_ADDRWIDTH'(G_MEMDEPTH)) ||
                    ((s_axi_arburst == WRAP) && !f_wrap_len_ok(s_axi_arlen));
`else
    assign ar_err = 1'b0;
`endif

    // Issue only if every beat already committed (buffer + array stage,
    // minus the one leaving now) leaves a free slot for the new one.
    assign committed = 3'(occ_q) + 3'(arr_vld_q) - 3'(pop);
    assign rd_issue  = (rd_state_q == R_BURST) && !rd_done_q && (committed <= 3'd1);

    axi_ram_addr_gen #(.G_ADDRWIDTH(G_ADDRWIDTH)) u_ar_gen (
        .clk     (s_aclk),
        .rst     (s_areset),
        .load_i  (ar_hs),
        .adv_i   (rd_issue),
        .addr_i  (s_axi_araddr),
        .len_i   (s_axi_arlen),
        .size_i  (s_axi_arsize),
        .burst_i (s_axi_arburst),
        .addr_o  (rd_addr),
        .last_o  (rd_last)
    );

    always_comb begin
        rd_state_d = rd_state_q;
        rid_d      = rid_q;
        rd_err_d   = rd_err_q;
        rd_done_d  = rd_done_q;
        case (rd_state_q)
            R_IDLE: if (s_axi_arvalid) begin
                rd_state_d = R_BURST;
                rid_d      = s_axi_arid;
                rd_err_d   = ar_err;
                rd_done_d  = 1'b0;
            end
            R_BURST: begin
                if (rd_issue && rd_last) rd_done_d = 1'b1;
                if (pop && head_last_q) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        push_data   = rd_err_q ? '0 : arr_data_q;
        after_pop   = occ_q - 2'(pop);
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        if (pop && (occ_q == 2'd2)) begin
            head_data_d = skid_data_q;
            head_last_d = skid_last_q;
        end
        if (arr_vld_q) begin
            if (after_pop == 2'd0) begin
                head_data_d = push_data;
                head_last_d = arr_last_q;
            end else begin
                skid_data_d = push_data;
                skid_last_d = arr_last_q;
            end
        end
        occ_d = after_pop + 2'(arr_vld_q);
    end

    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            rd_state_q  <= R_IDLE;
            rid_q       <= '0;
            rd_err_q    <= 1'b0;
            rd_done_q   <= 1'b0;
            arr_vld_q   <= 1'b0;
            occ_q       <= 2'd0;
            head_data_q <= '0;
            head_last_q <= 1'b0;
        end else begin
            rd_state_q  <= rd_state_d;
            rid_q       <= rid_d;
            rd_err_q    <= rd_err_d;
            rd_done_q   <= rd_done_d;
            arr_vld_q   <= rd_issue;
            occ_q       <= occ_d;
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
        end
    end

    always_ff @(posedge s_aclk) begin
        skid_data_q <= skid_data_d;
        skid_last_q <= skid_last_d;
        arr_last_q  <= rd_last;
    end

    // Separate process from the write port: a same-cycle write to this word
    // is not yet visible, so the read returns the old contents.
    always_ff @(posedge s_aclk) begin
        if (rd_issue) arr_data_q <= mem[rd_idx];
    end

    logic unused_ok;
    assign unused_ok = ^{s_axi_wlast, wr_addr, rd_addr};

endmodule

// File: tb/tb_axi_ram_burst.sv
`timescale 1ns/1ps
module tb_axi_ram_burst;

    localparam logic [1:0] B_FIXED = 2'b00;
    localparam logic [1:0] B_INCR  = 2'b01;
    localparam logic [1:0] B_WRAP  = 2'b10;
    localparam int         TMO     = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    always #5 clk = ~clk;

    axi_ram_burst #(
        .G_DATAWIDTH(32), .G_MEMDEPTH(1024), .G_ID_WIDTH(4), .G_ADDRWIDTH(32), .G_INIT_FILE("")
    ) dut (
        .s_aclk(clk), .s_areset(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic [31:0] rd_q [256];
    logic        rl_q [256];
    logic [1:0]  rr_q [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, output logic [1:0] resp);
        int t;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < TMO) begin @(posedge clk); #1; t++; end
        if (t >= TMO) check("aw_timeout", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wd[i]; wstrb = ws[i]; wlast = (i == int'(len)); wvalid = 1'b1;
            t = 0;
            while (!wready && t < TMO) begin @(posedge clk); #1; t++; end
            if (t >= TMO) check("w_timeout", 32'(wready), 32'd1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < TMO) begin @(posedge clk); #1; t++; end
        if (t >= TMO) check("b_timeout", 32'(bvalid), 32'd1);
        resp = bresp;
        check("bid", 32'(bid), 32'(id));
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit toggle, output int lat, output int n);
        int t;
        int cyc;
        logic [3:0] rid_first;
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < TMO) begin @(posedge clk); #1; t++; end
        if (t >= TMO) check("ar_timeout", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = -1; n = 0; cyc = 0; t = 0; rid_first = 4'd0;
        while (n <= int'(len) && t < 4000) begin
            rready = toggle ? ~cyc[0] : 1'b1;
            if (rvalid && lat < 0) lat = cyc;
            if (rvalid && rready) begin
                if (n == 0) rid_first = rid;
                rd_q[n] = rdata; rl_q[n] = rlast; rr_q[n] = rresp;
                n++;
            end
            @(posedge clk); #1;
            cyc++; t++;
        end
        rready = 1'b0;
        if (n <= int'(len)) check("r_timeout_beats", 32'(n), 32'(int'(len) + 1));
        check("rid", 32'(rid_first), 32'(id));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, 0 of 1 expected completions");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  resp, resp2;
        logic [31:0] exp_w0;
        logic [1:0]  exp_br;
        int lat, n, nbad, nlast, bseen;

        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_aw_ar_w_ready", 32'({awready, arready, wready}), 32'h6);
        check("rst_b_r_valid_last", 32'({bvalid, rvalid, rlast}), 32'h0);
        check("rst_bresp_rresp", 32'({bresp, rresp}), 32'h0);
        check("rst_bid_rid", 32'({bid, rid}), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single beat write and read-back, first-beat latency
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        axi_write(4'd3, 32'h10, 8'd0, B_INCR, resp);
        check("t1_bresp", 32'(resp), 32'd0);
        axi_read(4'd5, 32'h10, 8'd0, B_INCR, 1'b0, lat, n);
        check("t1_rdata", rd_q[0], 32'hDEADBEEF);
        check("t1_rlast", 32'(rl_q[0]), 32'd1);
        check("t1_rresp", 32'(rr_q[0]), 32'd0);
        check("t1_latency", 32'(lat), 32'd2);

        // Byte strobes over existing data
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        axi_write(4'd1, 32'h20, 8'd0, B_INCR, resp);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
        axi_write(4'd1, 32'h20, 8'd0, B_FIXED, resp);
        axi_read(4'd2, 32'h20, 8'd0, B_INCR, 1'b0, lat, n);
        check("t2_strobe_merge", rd_q[0], 32'h11BB33DD);

        // WRAP len=3 from 0x38: beats land on 0x38, 0x3C, 0x30, 0x34
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0000000 + 32'(i); ws[i] = 4'hF; end
        axi_write(4'd7, 32'h38, 8'd3, B_WRAP, resp);
        check("t3_bresp", 32'(resp), 32'd0);
        axi_read(4'd7, 32'h30, 8'd3, B_INCR, 1'b0, lat, n);
        check("t3_word_0x30", rd_q[0], 32'hA0000002);
        check("t3_word_0x34", rd_q[1], 32'hA0000003);
        check("t3_word_0x38", rd_q[2], 32'hA0000000);
        check("t3_word_0x3C", rd_q[3], 32'hA0000001);
        axi_read(4'd7, 32'h38, 8'd3, B_WRAP, 1'b0, lat, n);
        nbad = 0;
        for (int i = 0; i < 4; i++) if (rd_q[i] !== 32'hA0000000 + 32'(i)) nbad++;
        check("t3_wrap_read_order_bad_beats", 32'(nbad), 32'd0);
        check("t3_wrap_rlast", 32'({rl_q[0], rl_q[1], rl_q[2], rl_q[3]}), 32'h1);

        // 256-beat INCR read with rready toggling every cycle
        for (int i = 0; i < 256; i++) begin wd[i] = 32'hC0DE0000 + 32'(i); ws[i] = 4'hF; end
        axi_write(4'd4, 32'h400, 8'd255, B_INCR, resp);
        check("t4_bresp", 32'(resp), 32'd0);
        axi_read(4'd9, 32'h400, 8'd255, B_INCR, 1'b1, lat, n);
        check("t4_beats", 32'(n), 32'd256);
        nbad = 0; nlast = 0;
        for (int i = 0; i < 256; i++) begin
            if (rd_q[i] !== 32'hC0DE0000 + 32'(i)) nbad++;
            if (rl_q[i] !== (i == 255)) nlast++;
        end
        check("t4_data_bad_beats", 32'(nbad), 32'd0);
        check("t4_rlast_misplaced", 32'(nlast), 32'd0);

        // Concurrent write and read, AW and AR offered in the same cycle
        for (int i = 0; i < 8; i++) begin wd[i] = 32'h77000000 + 32'(i); ws[i] = 4'hF; end
        fork
            axi_write(4'd2, 32'h800, 8'd7, B_INCR, resp);
            axi_read(4'd6, 32'h400, 8'd7, B_INCR, 1'b0, lat, n);
        join
        check("t5_bresp", 32'(resp), 32'd0);
        nbad = 0;
        for (int i = 0; i < 8; i++) if (rd_q[i] !== 32'hC0DE0000 + 32'(i)) nbad++;
        check("t5_concurrent_read_bad_beats", 32'(nbad), 32'd0);
        axi_read(4'd6, 32'h800, 8'd7, B_INCR, 1'b0, lat, n);
        nbad = 0;
        for (int i = 0; i < 8; i++) if (rd_q[i] !== 32'h77000000 + 32'(i)) nbad++;
        check("t5_written_bad_beats", 32'(nbad), 32'd0);

        // Write to word G_MEMDEPTH (byte 0x1000)
        wd[0] = 32'h01234567; ws[0] = 4'hF;
        axi_write(4'd0, 32'h0, 8'd0, B_INCR, resp);
        wd[0] = 32'hFEEDFACE;
        axi_write(4'd0, 32'h1000, 8'd0, B_INCR, resp2);
`ifdef AXI_RAM_RANGE_CHECK_EN
        exp_br = 2'b10; exp_w0 = 32'h01234567;
`else
        exp_br = 2'b00; exp_w0 = 32'hFEEDFACE;
`endif
        check("t6_bresp_out_of_range", 32'(resp2), 32'(exp_br));
        axi_read(4'd0, 32'h0, 8'd0, B_INCR, 1'b0, lat, n);
        check("t6_word0", rd_q[0], exp_w0);
`ifdef AXI_RAM_RANGE_CHECK_EN
        axi_read(4'd0, 32'h1000, 8'd0, B_INCR, 1'b0, lat, n);
        check("t6_oor_rresp", 32'(rr_q[0]), 32'h2);
        check("t6_oor_rdata", rd_q[0], 32'h0);
`endif

        // Reset during beat 3 of an 8-beat write
        for (int i = 0; i < 8; i++) begin wd[i] = 32'h11110000 + 32'(i); ws[i] = 4'hF; end
        axi_write(4'd1, 32'h600, 8'd7, B_INCR, resp);
        awid = 4'd8; awaddr = 32'h600; awlen = 8'd7; awsize = 3'd2; awburst = B_INCR; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wdata = 32'h22220000 + 32'(i); wstrb = 4'hF; wvalid = 1'b1;
            @(posedge clk); #1;
        end
        wdata = 32'h22220003; wvalid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wvalid = 1'b0;
        check("t7_after_reset_aw_w_ready", 32'({awready, wready}), 32'h2);
        bready = 1'b1;
        bseen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bvalid) bseen++;
            @(posedge clk); #1;
        end
        bready = 1'b0;
        check("t7_bvalid_cycles", 32'(bseen), 32'd0);
        axi_read(4'd3, 32'h600, 8'd7, B_INCR, 1'b0, lat, n);
        nbad = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 3) begin
                if (rd_q[i] !== 32'h22220000 + 32'(i)) nbad++;
            end else begin
                if (rd_q[i] !== 32'h11110000 + 32'(i)) nbad++;
            end
        end
        check("t7_partial_burst_bad_words", 32'(nbad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
